// File: rtl/way_read_mux.sv
// way_read_mux: registered way-select stage with skid buffer for the cache read path.
//   i_clk, i_rst_n          clock, async active-low reset
//   i_valid/o_ready         input handshake (o_ready is registered: skid empty)
//   i_data, i_sel           per-way lines and tag-compare hit vector
//   i_word_idx, i_id        word index within the line, transaction ID
//   i_cnt_clr               synchronous clear of the multi-hit counter
//   o_valid/i_ready         output handshake
//   o_line, o_word, o_way   selected line, extracted word, encoded way
//   o_hit, o_multi_hit, o_id, o_multi_hit_cnt   status, ID, saturating multi-hit count
module way_read_mux #(
    parameter int LINE_SIZE_BYTES = 64,
    parameter int WAYS            = 4,
    parameter int WORD_BYTES      = 4,
    parameter int ID_W            = 4,
    parameter int CNT_W           = 8,
    localparam int LINE_BITS      = LINE_SIZE_BYTES * 8,
    localparam int WORD_BITS      = WORD_BYTES * 8,
    localparam int IDX_W          = $clog2(LINE_SIZE_BYTES / WORD_BYTES),
    localparam int WAY_W          = $clog2(WAYS)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [LINE_BITS-1:0] i_data [WAYS],
    input  logic [WAYS-1:0]      i_sel,
    input  logic [IDX_W-1:0]     i_word_idx,
    input  logic [ID_W-1:0]      i_id,
    input  logic                 i_cnt_clr,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [LINE_BITS-1:0] o_line,
    output logic [WORD_BITS-1:0] o_word,
    output logic [WAY_W-1:0]     o_way,
    output logic                 o_hit,
    output logic                 o_multi_hit,
    output logic [ID_W-1:0]      o_id,
    output logic [CNT_W-1:0]     o_multi_hit_cnt
);
    localparam int BEAT_W = LINE_BITS + WORD_BITS + WAY_W + 2 + ID_W;

    logic [LINE_BITS-1:0] line_sel;
    logic [WAY_W-1:0]     way_sel;
    logic                 sel_hit, sel_multi, accept;
    logic [BEAT_W-1:0]    beat_new;
    logic [BEAT_W-1:0]    out_d, out_q, skid_d, skid_q;
    logic                 out_valid_d, out_valid_q, skid_valid_d, skid_valid_q;
    logic [CNT_W-1:0]     cnt_d, cnt_q;

    // Descending scan so the lowest set way wins on multi-hit.
    always_comb begin
        line_sel = '0;
        way_sel  = '0;
        for (int k = WAYS - 1; k >= 0; k--) begin
            if (i_sel[k]) begin
                line_sel = i_data[k];
                way_sel  = WAY_W'(k);
            end
        end
    end

    assign sel_hit   = |i_sel;
    assign sel_multi = |(i_sel & (i_sel - WAYS'(1)));
    assign accept    = i_valid && o_ready;
    assign beat_new  = {line_sel, WORD_BITS'(line_sel >> (i_word_idx * WORD_BITS)),
                        way_sel, sel_hit, sel_multi, i_id};

    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (!out_valid_q || i_ready) begin
            // Skid beat is older than anything new; accept cannot happen while skid is full.
            out_valid_d  = skid_valid_q || accept;
            out_d        = skid_valid_q ? skid_q : accept ? beat_new : out_q;
            skid_valid_d = 1'b0;
        end else if (accept) begin
            skid_d       = beat_new;
            skid_valid_d = 1'b1;
        end
        cnt_d = i_cnt_clr ? '0 : (accept && sel_multi && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            cnt_q        <= cnt_d;
        end
    end

    assign {o_line, o_word, o_way, o_hit, o_multi_hit, o_id} = out_q;
    assign o_valid         = out_valid_q;
    assign o_ready         = !skid_valid_q;
    assign o_multi_hit_cnt = cnt_q;
endmodule

// File: tb/tb_way_read_mux.sv
// tb_way_read_mux: randomized scoreboard bench for way_read_mux.
module tb_way_read_mux;
    localparam int LB = 512, W = 4, IW = 4, CW = 8;

    typedef struct packed {
        logic [LB-1:0] line;
        logic [31:0]   word;
        logic [1:0]    way;
        logic          hit;
        logic          multi;
        logic [IW-1:0] id;
    } beat_t;

    logic          i_clk = 1'b0, i_rst_n = 1'b0;
    logic          i_valid = 1'b0, i_ready = 1'b0, i_cnt_clr = 1'b0;
    logic          o_ready, o_valid, o_hit, o_multi_hit;
    logic [LB-1:0] i_data [W];
    logic [W-1:0]  i_sel = '0;
    logic [3:0]    i_word_idx = '0;
    logic [IW-1:0] i_id = '0, o_id;
    logic [LB-1:0] o_line;
    logic [31:0]   o_word;
    logic [1:0]    o_way;
    logic [CW-1:0] o_multi_hit_cnt;
    beat_t         obs;
    beat_t         q[$];
    int            exp_cnt = 0;
    int            n_cmp = 0, n_bad = 0;

    assign obs = {o_line, o_word, o_way, o_hit, o_multi_hit, o_id};

    always #5 i_clk = ~i_clk;

    way_read_mux #(.LINE_SIZE_BYTES(64), .WAYS(W), .WORD_BYTES(4), .ID_W(IW), .CNT_W(CW)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_data(i_data), .i_sel(i_sel), .i_word_idx(i_word_idx), .i_id(i_id),
        .i_cnt_clr(i_cnt_clr), .o_valid(o_valid), .i_ready(i_ready), .o_line(o_line),
        .o_word(o_word), .o_way(o_way), .o_hit(o_hit), .o_multi_hit(o_multi_hit),
        .o_id(o_id), .o_multi_hit_cnt(o_multi_hit_cnt)
    );

    task automatic rand_line(output logic [LB-1:0] l);
        for (int j = 0; j < LB / 32; j++) l[j*32 +: 32] = $urandom;
    endtask

    task automatic rand_data();
        for (int k = 0; k < W; k++) rand_line(i_data[k]);
    endtask

    task automatic rand_inputs();
        i_valid    = 1'($urandom);
        i_ready    = 1'($urandom);
        i_sel      = 4'($urandom);
        i_word_idx = 4'($urandom);
        i_id       = 4'($urandom);
        i_cnt_clr  = 1'($urandom);
        rand_data();
    endtask

    // Reference: the beat the stage should produce for the inputs currently driven.
    function automatic beat_t ref_beat();
        beat_t b = '0;
        int w = -1;
        for (int k = 0; k < W; k++) if (i_sel[k] && w < 0) w = k;
        if (w >= 0) begin
            b.line = i_data[w];
            b.way  = 2'(w);
            b.word = 32'(i_data[w] >> (i_word_idx * 32));
        end
        b.hit   = i_sel != 0;
        b.multi = $countones(i_sel) > 1;
        b.id    = i_id;
        return b;
    endfunction

    // Called just before a rising edge: applies that edge's handshakes to the model, then steps.
    task automatic edge_step();
        bit    acc = i_valid && o_ready;
        beat_t nb  = ref_beat();
        if (o_valid && i_ready && q.size() > 0) q.delete(0);
        if (acc) q.push_back(nb);
        if (i_cnt_clr) exp_cnt = 0;
        else if (acc && nb.multi && exp_cnt < 255) exp_cnt++;
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        rand_inputs();
        @(negedge i_clk);
        n_cmp++;
        if ({o_valid, o_ready, o_multi_hit_cnt, obs} !== {1'b0, 1'b1, 8'd0, beat_t'(0)}) begin
            n_bad++;
            $display("FAIL reset_initial: valid=%b ready=%b cnt=%0d id=%0d way=%0d word=%h (need 0/1/0/0/0/0)",
                     o_valid, o_ready, o_multi_hit_cnt, o_id, o_way, o_word);
        end
        i_valid = 1'b0; i_cnt_clr = 1'b0;
        i_rst_n = 1'b1;
        q.delete(); exp_cnt = 0;
        @(posedge i_clk); #1;
        for (int c = 0; c < 6; c++) begin
            i_valid = 1'b1; i_sel = 4'b1111; i_ready = 1'b0; i_id = 4'($urandom);
            rand_data();
            @(negedge i_clk);
            edge_step();
        end
        #2 i_rst_n = 1'b0;
        rand_inputs();
        #1;
        n_cmp++;
        if ({o_valid, o_ready, o_multi_hit_cnt, obs} !== {1'b0, 1'b1, 8'd0, beat_t'(0)}) begin
            n_bad++;
            $display("FAIL reset_async: valid=%b ready=%b cnt=%0d id=%0d way=%0d (need 0/1/0/0/0)",
                     o_valid, o_ready, o_multi_hit_cnt, o_id, o_way);
        end
        @(negedge i_clk);
        n_cmp++;
        if ({o_valid, o_ready, o_multi_hit_cnt, obs} !== {1'b0, 1'b1, 8'd0, beat_t'(0)}) begin
            n_bad++;
            $display("FAIL reset_held: valid=%b ready=%b cnt=%0d id=%0d (need 0/1/0/0)",
                     o_valid, o_ready, o_multi_hit_cnt, o_id);
        end
        i_rst_n = 1'b1;
        q.delete(); exp_cnt = 0;
        i_valid = 1'b1; i_sel = 4'b0001; i_word_idx = 4'd0; i_id = 4'd9; i_ready = 1'b1; i_cnt_clr = 1'b0;
        rand_data();
        n_cmp++;
        if (o_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_no_early_valid: o_valid=%b need 0", o_valid);
        end
        edge_step();
        i_valid = 1'b0;
        @(negedge i_clk);
        n_cmp++;
        if (o_valid !== 1'b1 || o_id !== 4'd9 || obs !== q[0]) begin
            n_bad++;
            $display("FAIL reset_first_beat: valid=%b id=%0d way=%0d word=%h need 1/9/0/%h",
                     o_valid, o_id, o_way, o_word, q[0].word);
        end
        edge_step();
    endtask

    task automatic test_select();
        logic [31:0] top;
        i_ready = 1'b1; i_cnt_clr = 1'b0; i_valid = 1'b1;
        for (int k = 0; k < W; k++) i_data[k] = {64{8'(k + 1)}};
        i_sel = 4'b0100; i_word_idx = 4'd3; i_id = 4'd1;
        @(negedge i_clk);
        edge_step();
        i_sel = 4'b0000; i_word_idx = 4'($urandom); i_id = 4'd2;
        @(negedge i_clk);
        n_cmp++;
        if ({o_valid, o_way, o_hit, o_multi_hit, o_word} !== {1'b1, 2'd2, 1'b1, 1'b0, 32'h03030303}) begin
            n_bad++;
            $display("FAIL select_onehot: valid=%b way=%0d hit=%b multi=%b word=%h need 1/2/1/0/03030303",
                     o_valid, o_way, o_hit, o_multi_hit, o_word);
        end
        n_cmp++;
        if (o_line !== {64{8'h03}}) begin
            n_bad++;
            $display("FAIL select_line: o_line[31:0]=%h need 03030303 across the whole line", o_line[31:0]);
        end
        edge_step();
        i_sel = 4'b1010; i_id = 4'd3;
        @(negedge i_clk);
        n_cmp++;
        if ({o_valid, o_hit, o_multi_hit, o_way, o_word, o_id} !== {1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 4'd2} ||
            o_line !== '0) begin
            n_bad++;
            $display("FAIL select_miss: valid=%b hit=%b multi=%b way=%0d word=%h id=%0d need 1/0/0/0/0/2",
                     o_valid, o_hit, o_multi_hit, o_way, o_word, o_id);
        end
        edge_step();
        rand_line(i_data[0]);
        top = i_data[0][511:480];
        i_sel = 4'b0001; i_word_idx = 4'd15; i_id = 4'd4;
        @(negedge i_clk);
        n_cmp++;
        if ({o_valid, o_way, o_hit, o_multi_hit, o_multi_hit_cnt} !== {1'b1, 2'd1, 1'b1, 1'b1, 8'd1}) begin
            n_bad++;
            $display("FAIL select_multi: valid=%b way=%0d hit=%b multi=%b cnt=%0d need 1/1/1/1/1",
                     o_valid, o_way, o_hit, o_multi_hit, o_multi_hit_cnt);
        end
        edge_step();
        i_valid = 1'b0;
        rand_line(i_data[0]);
        @(negedge i_clk);
        n_cmp++;
        if ({o_valid, o_word, o_way} !== {1'b1, top, 2'd0}) begin
            n_bad++;
            $display("FAIL select_top_word: valid=%b word=%h way=%0d need 1/%h/0", o_valid, o_word, o_way, top);
        end
        edge_step();
    endtask

    task automatic test_back_to_back();
        int    nid = 0;
        int    got[$];
        bit    held = 0, saw_drop = 0;
        beat_t held_beat = '0;
        for (int c = 0; c < 40 && got.size() < 8; c++) begin
            i_valid = nid < 8; i_id = 4'(nid); i_cnt_clr = 1'b0;
            i_sel = 4'(1 << $urandom_range(3)); i_word_idx = 4'($urandom);
            rand_data();
            i_ready = !(c >= 3 && c < 6);
            @(negedge i_clk);
            if (held) begin
                n_cmp++;
                if (o_valid !== 1'b1 || obs !== held_beat) begin
                    n_bad++;
                    $display("FAIL b2b_stable: valid=%b id=%0d word=%h need 1/%0d/%h",
                             o_valid, o_id, o_word, held_beat.id, held_beat.word);
                end
            end
            n_cmp++;
            if (o_ready !== (q.size() < 2)) begin
                n_bad++;
                $display("FAIL b2b_ready: o_ready=%b need %b", o_ready, q.size() < 2);
            end
            if (o_ready === 1'b0) saw_drop = 1;
            if (o_valid && i_ready) begin
                got.push_back(int'(o_id));
                n_cmp++;
                if (q.size() == 0 || obs !== q[0]) begin
                    n_bad++;
                    $display("FAIL b2b_beat: id=%0d way=%0d word=%h need id=%0d way=%0d word=%h",
                             o_id, o_way, o_word, q.size() ? q[0].id : 4'hx, q.size() ? q[0].way : 2'bx,
                             q.size() ? q[0].word : 32'hx);
                end
            end
            held = o_valid && !i_ready;
            held_beat = obs;
            if (i_valid && o_ready) nid++;
            edge_step();
        end
        n_cmp++;
        if (got.size() != 8) begin
            n_bad++;
            $display("FAIL b2b_count: received %0d beats need 8", got.size());
        end
        for (int i = 0; i < got.size(); i++) begin
            n_cmp++;
            if (got[i] != i) begin
                n_bad++;
                $display("FAIL b2b_order: position %0d id=%0d need %0d", i, got[i], i);
            end
        end
        n_cmp++;
        if (!saw_drop) begin
            n_bad++;
            $display("FAIL b2b_ready_drop: o_ready never fell during the stall, need a drop");
        end
        i_valid = 1'b0;
    endtask

    task automatic test_random();
        bit    held = 0;
        beat_t held_beat = '0;
        for (int c = 0; c < 400; c++) begin
            i_valid    = c < 394 ? ($urandom_range(9) < 7) : 1'b0;
            i_ready    = c < 394 ? ($urandom_range(9) < 6) : 1'b1;
            i_cnt_clr  = $urandom_range(19) == 0;
            case ($urandom_range(2))
                0:       i_sel = '0;
                1:       i_sel = 4'(1 << $urandom_range(3));
                default: i_sel = 4'($urandom);
            endcase
            i_word_idx = 4'($urandom);
            i_id       = 4'($urandom);
            rand_data();
            @(negedge i_clk);
            n_cmp++;
            if (o_valid !== (q.size() > 0) || o_ready !== (q.size() < 2)) begin
                n_bad++;
                $display("FAIL rand_flow: cycle %0d valid=%b ready=%b need %b/%b",
                         c, o_valid, o_ready, q.size() > 0, q.size() < 2);
            end
            n_cmp++;
            if (o_multi_hit_cnt !== CW'(exp_cnt)) begin
                n_bad++;
                $display("FAIL rand_cnt: cycle %0d cnt=%0d need %0d", c, o_multi_hit_cnt, exp_cnt);
            end
            if (held) begin
                n_cmp++;
                if (obs !== held_beat) begin
                    n_bad++;
                    $display("FAIL rand_stable: cycle %0d id=%0d word=%h need %0d/%h",
                             c, o_id, o_word, held_beat.id, held_beat.word);
                end
            end
            if (o_valid && i_ready && q.size() > 0) begin
                n_cmp++;
                if (obs !== q[0]) begin
                    n_bad++;
                    $display("FAIL rand_beat: cycle %0d id=%0d way=%0d hit=%b multi=%b word=%h need %0d/%0d/%b/%b/%h",
                             c, o_id, o_way, o_hit, o_multi_hit, o_word,
                             q[0].id, q[0].way, q[0].hit, q[0].multi, q[0].word);
                end
            end
            held = o_valid && !i_ready;
            held_beat = obs;
            edge_step();
        end
        i_cnt_clr = 1'b0;
    endtask

    task automatic test_saturation();
        i_ready = 1'b1; i_valid = 1'b1; i_sel = 4'b0110; i_cnt_clr = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge i_clk);
            edge_step();
        end
        @(negedge i_clk);
        n_cmp++;
        if (o_multi_hit_cnt !== 8'd255) begin
            n_bad++;
            $display("FAIL sat_cnt: cnt=%0d need 255", o_multi_hit_cnt);
        end
        i_cnt_clr = 1'b1;
        edge_step();
        i_cnt_clr = 1'b0;
        i_valid = 1'b0;
        @(negedge i_clk);
        n_cmp++;
        if (o_multi_hit_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL sat_clear_wins: cnt=%0d need 0", o_multi_hit_cnt);
        end
        edge_step();
    endtask

    initial begin
        test_reset();
        test_select();
        test_back_to_back();
        test_random();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
